// File: rtl/dbg_pkg.sv
// Shared constants for the register-file debug read path: state encoding and
// default index/data widths.
package dbg_pkg;

  localparam int unsigned AW_DEF = 5;
  localparam int unsigned DW_DEF = 32;
  localparam int unsigned ST_W   = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_READ = 2'd1;
  localparam logic [ST_W-1:0] ST_SEND = 2'd2;
  localparam logic [ST_W-1:0] ST_FIN  = 2'd3;

endpackage

// File: rtl/reg_shadow.sv
// Shadow copy of the register file used by diff-mode dumps: one write port,
// one combinational compare against the incoming read data.
module reg_shadow
  import dbg_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [DW-1:0] wdata,
  output logic          match
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];

  // Cleared on reset so the first diff dump reports every nonzero register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[idx] <= wdata;
    end
  end

  assign match = (mem_q[idx] == wdata);

endmodule

// File: rtl/reg_dump_reader.sv
// Walks the register file debug port over FIRST_IDX..LAST_IDX and streams
// (index, value) records over valid/ready, optionally only changed ones.
module reg_dump_reader
  import dbg_pkg::*;
#(
  parameter int unsigned AW        = AW_DEF,
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned FIRST_IDX = 0,
  parameter int unsigned LAST_IDX  = 31
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          diff_only,
  input  logic          abort,
  output logic [AW-1:0] debug_ra,
  input  logic [DW-1:0] debug_rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] FIRST_A = AW'(FIRST_IDX);
  localparam logic [AW-1:0] LAST_A  = AW'(LAST_IDX);

  logic [ST_W-1:0] state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [AW-1:0]   ra_q, ra_d;
  logic            valid_q, valid_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            diff_q, diff_d;

  logic            shadow_we;
  logic            shadow_match;
  logic            advance;

  reg_shadow #(
    .AW (AW),
    .DW (DW)
  ) u_shadow (
    .clk   (clk),
    .rstn  (rstn),
    .we    (shadow_we),
    .idx   (idx_q),
    .wdata (debug_rd),
    .match (shadow_match)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ra_q    <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ra_q    <= ra_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
    end
  end

  // Next-state logic; abort takes priority over any pending handshake or write.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ra_d      = ra_q;
    valid_d   = valid_q;
    addr_d    = addr_q;
    data_d    = data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    diff_d    = diff_q;
    shadow_we = 1'b0;
    advance   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          diff_d  = diff_only;
          idx_d   = FIRST_A;
          ra_d    = FIRST_A;
          busy_d  = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (abort) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          shadow_we = 1'b1;
          data_d    = debug_rd;
          addr_d    = idx_q;
          if (diff_q && shadow_match) begin
            advance = 1'b1;
          end else begin
            valid_d = 1'b1;
            state_d = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (abort) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (out_ready) begin
          valid_d = 1'b0;
          advance = 1'b1;
        end
      end
      ST_FIN: begin
        done_d  = ~abort;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // Terminates on the index compare so LAST_IDX = 2^AW-1 never wraps.
    if (advance) begin
      if (idx_q == LAST_A) begin
        state_d = ST_FIN;
      end else begin
        idx_d   = idx_q + AW'(1);
        ra_d    = idx_q + AW'(1);
        state_d = ST_READ;
      end
    end
  end

  assign debug_ra  = ra_q;
  assign out_valid = valid_q;
  assign out_addr  = addr_q;
  assign out_data  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: transaction-level model of the dump
// (expected record list, shadow copy, cycle cost) checked every cycle.
module tb_reg_dump_reader;

  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
  localparam int unsigned NREG = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, start, diff_only, abort, out_ready;
  logic [AW-1:0] debug_ra, out_addr;
  logic [DW-1:0] debug_rd, out_data;
  logic          out_valid, busy, done;

  logic          s_start, s_out_ready;
  logic [AW-1:0] s_debug_ra, s_out_addr;
  logic [DW-1:0] s_debug_rd, s_out_data;
  logic          s_out_valid, s_busy, s_done;

  logic [DW-1:0] regs     [NREG];
  logic [DW-1:0] shadow_m [NREG];

  assign debug_rd   = regs[debug_ra];
  assign s_debug_rd = regs[s_debug_ra];

  reg_dump_reader #(.AW(AW), .DW(DW), .FIRST_IDX(0), .LAST_IDX(31)) dut (
    .clk(clk), .rstn(rstn), .start(start), .diff_only(diff_only), .abort(abort),
    .debug_ra(debug_ra), .debug_rd(debug_rd), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done)
  );

  reg_dump_reader #(.AW(AW), .DW(DW), .FIRST_IDX(31), .LAST_IDX(31)) dut1 (
    .clk(clk), .rstn(rstn), .start(s_start), .diff_only(1'b0), .abort(1'b0),
    .debug_ra(s_debug_ra), .debug_rd(s_debug_rd), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_addr(s_out_addr), .out_data(s_out_data),
    .busy(s_busy), .done(s_done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] exp_addr [NREG];
  logic [DW-1:0] exp_data [NREG];
  int  exp_n, n_xfer, exp_lat, start_cyc, last_lat, done_cnt;
  bit  exp_busy, lat_check, hold_prev, prev_done, stall_chk;
  logic [AW-1:0] held_addr;
  logic [DW-1:0] held_data;
  int  rdy_mode, stall_left;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    bad++;
    $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  task automatic cycle_check();
    if (!rstn) begin
      hold_prev = 1'b0;
      prev_done = 1'b0;
      return;
    end
    check("busy", 64'(busy), 64'(exp_busy && !done));
    if (!exp_busy) check("idle_valid", 64'(out_valid), 64'd0);
    if (hold_prev) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_addr", 64'(out_addr), 64'(held_addr));
      check("hold_data", 64'(out_data), 64'(held_data));
    end
    if (stall_chk && out_valid && !out_ready) begin
      check("stall_addr", 64'(out_addr), 64'd3);
      check("stall_data", 64'(out_data), 64'h33333333);
    end
    if (out_valid && out_ready && !abort) begin
      if (n_xfer >= exp_n) begin
        fail_now("extra_record", 64'(out_addr), 64'(exp_n));
      end else begin
        check("rec_addr", 64'(out_addr), 64'(exp_addr[n_xfer]));
        check("rec_data", 64'(out_data), 64'(exp_data[n_xfer]));
      end
      n_xfer++;
    end
    hold_prev = out_valid && !out_ready && !abort;
    held_addr = out_addr;
    held_data = out_data;
    if (done) begin
      if (prev_done) fail_now("done_width", 64'd2, 64'd1);
      if (!exp_busy) fail_now("spurious_done", 64'd1, 64'd0);
      check("done_count", 64'(n_xfer), 64'(exp_n));
      last_lat = cyc - start_cyc;
      if (lat_check) check("done_latency", 64'(last_lat), 64'(exp_lat));
      done_cnt++;
    end
    prev_done = done;
  endtask

  task automatic tick();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    #1;
    case (rdy_mode)
      1: out_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (out_valid && out_addr == AW'(3) && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
        end
      end
      default: out_ready = 1'b1;
    endcase
  endtask

  // Expected records and cycle cost: a skipped register costs 1 cycle,
  // an emitted one 2 (READ + SEND with ready high), plus the FIN cycle.
  task automatic build_expect(input bit diff);
    int n = 0;
    for (int i = 0; i < NREG; i++) begin
      if (!diff || regs[i] !== shadow_m[i]) begin
        exp_addr[n] = AW'(i);
        exp_data[n] = regs[i];
        n++;
      end
    end
    exp_n   = n;
    n_xfer  = 0;
    exp_lat = 1 + (NREG - n) + 2 * n;
  endtask

  task automatic run_dump(input bit diff, input int abort_sel, input bit poke);
    int d0;
    int target;
    bit found;
    build_expect(diff);
    target = (abort_sel >= 0 && exp_n > 0) ? int'(exp_addr[abort_sel % exp_n]) : -1;
    diff_only = diff;
    start = 1'b1;
    tick();
    start = 1'b0;
    start_cyc = cyc;
    exp_busy = 1'b1;
    if (target >= 0) begin
      found = 1'b0;
      for (int k = 0; k < 2000 && !found; k++) begin
        if (out_valid && out_addr == AW'(target)) found = 1'b1;
        else tick();
      end
      if (!found) fail_now("abort_wait", 64'd0, 64'(target));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      exp_busy = 1'b0;
      check("abort_valid", 64'(out_valid), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      for (int i = 0; i <= target; i++) shadow_m[i] = regs[i];
    end else begin
      d0 = done_cnt;
      for (int k = 0; k < 3000 && done_cnt == d0; k++) begin
        tick();
        if (poke) start = ((cyc - start_cyc) == 10 || (cyc - start_cyc) == 64);
      end
      if (done_cnt == d0) fail_now("done_timeout", 64'd0, 64'd1);
      start = 1'b0;
      exp_busy = 1'b0;
      for (int i = 0; i < NREG; i++) shadow_m[i] = regs[i];
    end
  endtask

  task automatic run_single();
    int st, recs, dseen, lat;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    st = cyc;
    recs = 0;
    dseen = 0;
    lat = -1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (s_out_valid && s_out_ready) begin
        recs++;
        check("single_addr", 64'(s_out_addr), 64'd31);
        check("single_data", 64'(s_out_data), 64'(regs[31]));
      end
      if (s_done) begin
        dseen++;
        lat = cyc - st;
      end
    end
    check("single_recs", 64'(recs), 64'd1);
    check("single_done", 64'(dseen), 64'd1);
    check("single_lat", 64'(lat), 64'd3);
    check("single_busy", 64'(s_busy), 64'd0);
  endtask

  initial begin
    int d;
    for (int i = 0; i < NREG; i++) begin
      regs[i]     = 32'(i) * 32'h11111111;
      shadow_m[i] = '0;
    end
    rstn = 1'b0; start = 1'b0; diff_only = 1'b0; abort = 1'b0; out_ready = 1'b1;
    s_start = 1'b0; s_out_ready = 1'b1;
    rdy_mode = 0; stall_left = 0; stall_chk = 1'b0; lat_check = 1'b0;
    exp_busy = 1'b0; hold_prev = 1'b0; prev_done = 1'b0;
    exp_n = 0; n_xfer = 0; exp_lat = 0; start_cyc = 0; last_lat = 0; done_cnt = 0;
    held_addr = '0; held_data = '0;

    #12;
    check("rst_ra", 64'(debug_ra), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_addr", 64'(out_addr), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (2) tick();

    // Full dump, ready tied high.
    lat_check = 1'b1;
    run_dump(1'b0, -1, 1'b0);
    check("model_x3", 64'(exp_data[3]), 64'h33333333);
    check("full_lat", 64'(last_lat), 64'd65);
    check("full_count", 64'(n_xfer), 64'd32);

    // Backpressure on record 3 for 5 cycles.
    lat_check = 1'b0; rdy_mode = 2; stall_left = 5; stall_chk = 1'b1;
    run_dump(1'b0, -1, 1'b0);
    stall_chk = 1'b0; rdy_mode = 0;
    check("stall_used", 64'(stall_left), 64'd0);
    check("bp_count", 64'(n_xfer), 64'd32);

    // Diff dump after one register write.
    regs[5] = 32'hDEADBEEF;
    lat_check = 1'b1;
    run_dump(1'b1, -1, 1'b0);
    check("diff_count", 64'(n_xfer), 64'd1);
    check("model_diff_addr", 64'(exp_addr[0]), 64'd5);
    check("diff_lat", 64'(last_lat), 64'd34);

    // Abort in SEND of record 10, then a clean restart from index 0.
    lat_check = 1'b0;
    d = done_cnt;
    run_dump(1'b0, 10, 1'b0);
    repeat (5) tick();
    check("abort_no_done", 64'(done_cnt), 64'(d));
    lat_check = 1'b1;
    run_dump(1'b0, -1, 1'b0);
    check("restart_count", 64'(n_xfer), 64'd32);

    // Reset in the middle of a dump.
    build_expect(1'b0);
    diff_only = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; start_cyc = cyc; exp_busy = 1'b1;
    repeat (20) tick();
    rstn = 1'b0;
    #1;
    check("mid_rst_ra", 64'(debug_ra), 64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_addr", 64'(out_addr), 64'd0);
    check("mid_rst_data", 64'(out_data), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    exp_busy = 1'b0;
    for (int i = 0; i < NREG; i++) shadow_m[i] = '0;
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    run_dump(1'b1, -1, 1'b0);
    check("post_rst_diff_count", 64'(n_xfer), 64'd31);

    // Extra start while busy and during FIN must be ignored.
    run_dump(1'b0, -1, 1'b1);
    repeat (4) tick();
    check("poke_lat", 64'(last_lat), 64'd65);

    run_single();

    // Randomized dumps: random writes, mode, backpressure and aborts.
    for (int it = 0; it < 16; it++) begin
      int nw;
      bit dm;
      int asel;
      nw = int'($urandom_range(0, 4));
      for (int w = 0; w < nw; w++) regs[$urandom_range(1, 31)] = $urandom;
      dm = 1'($urandom_range(0, 1));
      rdy_mode = int'($urandom_range(0, 1));
      asel = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1;
      lat_check = (rdy_mode == 0);
      run_dump(dm, asel, 1'b0);
      rdy_mode = 0;
      repeat (2) tick();
    end

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
